// File: rtl/neuron_sequencer_if.sv
// Signal bundle for neuron_sequencer: input pair stream, neuron Datapath drive,
// and the 1-bit result stream. master = sequencer side, slave = environment side.
interface neuron_sequencer_if #(
  parameter int N = 16
);
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_x;
  logic signed [N-1:0] in_w;
  logic signed [N-1:0] x;
  logic signed [N-1:0] weight;
  logic                clear_acc;
  logic                acc_en;
  logic                ready;
  logic                data_out;
  logic                out_valid;
  logic                out_ready;
  logic                out_bit;

  modport master (
    input  in_valid, in_x, in_w, data_out, out_ready,
    output in_ready, x, weight, clear_acc, acc_en, ready, out_valid, out_bit
  );

  modport slave (
    output in_valid, in_x, in_w, data_out, out_ready,
    input  in_ready, x, weight, clear_acc, acc_en, ready, out_valid, out_bit
  );
endinterface

// File: rtl/neuron_sequencer.sv
// Buffers d (x, weight) pairs, replays them into the neuron Datapath and returns the
// activation bit on a valid/ready stream. Optional bias MAC cycle: define NEURON_BIAS_EN.
module neuron_sequencer #(
  parameter int N = 16,
  parameter int Q = 8,
  parameter int d = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                abort,
`ifdef NEURON_BIAS_EN
  input  logic                bias_wr,
  input  logic signed [N-1:0] bias_in,
`endif
  neuron_sequencer_if.master  bus
);

  localparam int IW = $clog2(d + 2);
  localparam int AW = (d > 1) ? $clog2(d) : 1;
`ifdef NEURON_BIAS_EN
  localparam int MAC_LEN = d + 1;
  localparam logic [IW-1:0]       BIAS_IDX = IW'(d);
  localparam logic signed [N-1:0] ONE      = N'(1 << Q);
`else
  localparam int MAC_LEN = d;
`endif
  localparam logic [IW-1:0] LAST_BEAT = IW'(d - 1);
  localparam logic [IW-1:0] LAST_MAC  = IW'(MAC_LEN - 1);

  if (d < 1 || Q < 0 || Q >= N) begin : g_bad_cfg
    $error("neuron_sequencer: invalid N/Q/d configuration");
  end

  typedef enum logic [2:0] {LOAD, CLEAR, MAC, FIRE, DONE} state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       idx, idx_nx;
  logic signed [N-1:0] pair_x [d];
  logic signed [N-1:0] pair_w [d];
  logic signed [N-1:0] x_nx, w_nx;
`ifdef NEURON_BIAS_EN
  logic signed [N-1:0] bias;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Next state; idx counts accepted beats in LOAD and replayed pairs in MAC
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (abort) begin
      state_nx = LOAD;
      idx_nx   = '0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid) begin
            if (idx == LAST_BEAT) begin
              state_nx = CLEAR;
              idx_nx   = '0;
            end else begin
              idx_nx = idx + 1'b1;
            end
          end
        end
        CLEAR: begin
          state_nx = MAC;
          idx_nx   = '0;
        end
        MAC: begin
          if (idx == LAST_MAC) begin
            state_nx = FIRE;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
        FIRE: state_nx = DONE;
        DONE: if (bus.out_ready) state_nx = LOAD;
        default: begin
          state_nx = LOAD;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // Strobes decode straight from state, so CLEAR and MAC can never overlap
  always_comb begin
    bus.in_ready  = (state == LOAD);
    bus.clear_acc = (state == CLEAR);
    bus.acc_en    = (state == MAC);
    bus.ready     = (state == FIRE);
    bus.out_valid = (state == DONE);
  end

  // Look one cycle ahead so pair k is registered onto x/weight for MAC cycle k
  always_comb begin
    x_nx = '0;
    w_nx = '0;
    if (state_nx == MAC) begin
      x_nx = pair_x[idx_nx[AW-1:0]];
      w_nx = pair_w[idx_nx[AW-1:0]];
`ifdef NEURON_BIAS_EN
      if (idx_nx == BIAS_IDX) begin
        x_nx = ONE;
        w_nx = bias;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.x       <= '0;
      bus.weight  <= '0;
      bus.out_bit <= 1'b0;
    end else begin
      bus.x      <= x_nx;
      bus.weight <= w_nx;
      if (state == FIRE && !abort) bus.out_bit <= bus.data_out;
    end
  end

  // Pair buffer is always rewritten before it is read, so it carries no reset
  always_ff @(posedge clk) begin
    if (state == LOAD && bus.in_valid && !abort) begin
      pair_x[idx[AW-1:0]] <= bus.in_x;
      pair_w[idx[AW-1:0]] <= bus.in_w;
    end
  end

`ifdef NEURON_BIAS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias <= '0;
    end else if (bias_wr && (state == LOAD || state == DONE)) begin
      bias <= bias_in;
    end
  end
`endif

endmodule
